// File: rtl/mod_updown_counter_pkg.sv
// Shared encodings and helpers for the modulus up/down counter and its adder.
package mod_updown_counter_pkg;

  localparam int unsigned DEF_WIDTH   = 5;
  localparam int unsigned DEF_MODULUS = 32;
  localparam int unsigned DEF_MAX_VAL = DEF_MODULUS - 1;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Largest count value for a given modulus.
  function automatic int unsigned max_val(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/mod_updown_counter_rca_nbit.sv
// One-bit full-adder cell and the parametrised ripple-carry adder built from it.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_nbit #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  // Carry ripples from bit 0 upward through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .sum  (sum[i]),
      .cout (w_carry[i+1])
    );
  end

  assign cout = w_carry[WIDTH];

endmodule

// File: rtl/mod_updown_counter.sv
// Registered up/down counter with programmable modulus, per-cycle step and
// wrap/saturate boundary handling; tc pulses and sticky ovf on boundary events.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned MODULUS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] step,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned        W1      = WIDTH + 1;
  localparam logic [W1-1:0]      MOD_EXT = W1'(MODULUS);
  localparam logic [WIDTH-1:0]   MOD_LO  = WIDTH'(MODULUS);
  localparam logic [WIDTH-1:0]   MAX_CNT = WIDTH'(max_val(MODULUS));

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic             w_up;
  logic [W1-1:0]    w_add_b;
  logic [W1-1:0]    w_sum;
  logic             w_sum_cout;
  logic [WIDTH-1:0] w_corr_b;
  logic [WIDTH-1:0] w_corr;
  logic             w_corr_cout_unused;
  logic             w_event;
  logic             w_load_oor;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_ovf_set;
  logic             w_ovf_nxt;

  assign w_up = (up_dn == DIR_UP);

  // Step add (up) or two's-complement subtract (down) at WIDTH+1 bits.
  assign w_add_b = w_up ? {1'b0, step} : ~{1'b0, step};

  rca_nbit #(.WIDTH(W1)) u_step_add (
    .a    ({1'b0, r_count}),
    .b    (w_add_b),
    .cin  (~w_up),
    .sum  (w_sum),
    .cout (w_sum_cout)
  );

  // Wrap correction: subtract MODULUS after an up overflow, add it after a borrow.
  assign w_corr_b = w_up ? ~MOD_LO : MOD_LO;

  rca_nbit #(.WIDTH(WIDTH)) u_mod_corr (
    .a    (w_sum[WIDTH-1:0]),
    .b    (w_corr_b),
    .cin  (w_up),
    .sum  (w_corr),
    .cout (w_corr_cout_unused)
  );

  assign w_event    = w_up ? (w_sum >= MOD_EXT) : ~w_sum_cout;
  assign w_load_oor = ({1'b0, load_val} >= MOD_EXT);

  // Next-state selection: load over enabled step over hold.
  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_ovf_set   = 1'b0;
    if (load) begin
      if (w_load_oor) begin
        w_count_nxt = MAX_CNT;
        w_ovf_set   = 1'b1;
      end else begin
        w_count_nxt = load_val;
      end
    end else if (en) begin
      if (w_event) begin
        w_tc_nxt  = 1'b1;
        w_ovf_set = 1'b1;
        if (mode == MODE_SAT) begin
          w_count_nxt = w_up ? MAX_CNT : '0;
        end else begin
          w_count_nxt = w_corr;
        end
      end else begin
        w_count_nxt = w_sum[WIDTH-1:0];
      end
    end
    w_ovf_nxt = w_ovf_set | (r_ovf & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector bench for mod_updown_counter (WIDTH=5, MODULUS=24) with a
// queue scoreboard checked by an independent monitor each cycle.
module tb_mod_updown_counter;

  localparam int unsigned W = 5;
  localparam int unsigned M = 24;

  typedef struct {
    string        name;
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic [W-1:0] step;
  logic         mode;
  logic         load;
  logic [W-1:0] load_val;
  logic         clr_ovf;
  logic [W-1:0] count;
  logic         tc;
  logic         ovf;

  exp_t exp_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .step     (step),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the hand-computed result of that edge.
  task automatic vec(input string nm, input int rn, input int ld, input int lv,
                     input int en_i, input int ud, input int st, input int md,
                     input int cl, input int ec, input int et, input int eo);
    exp_t x;
    @(negedge clk);
    rst_n    = 1'(rn);
    load     = 1'(ld);
    load_val = W'(lv);
    en       = 1'(en_i);
    up_dn    = 1'(ud);
    step     = W'(st);
    mode     = 1'(md);
    clr_ovf  = 1'(cl);
    x.name = nm;
    x.cnt  = W'(ec);
    x.tc   = 1'(et);
    x.ovf  = 1'(eo);
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (count !== e.cnt || tc !== e.tc || ovf !== e.ovf) begin
          n_err++;
          $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, want count=%0d tc=%0b ovf=%0b",
                   e.name, count, tc, ovf, e.cnt, e.tc, e.ovf);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; step = W'(3); mode = 1'b0;
    load = 1'b0; load_val = '0; clr_ovf = 1'b0;

    //   name            rn ld lv en ud st md cl  cnt tc ovf
    vec("rst_a",          0, 0, 0, 1, 1, 3, 0, 0,  0, 0, 0);
    vec("rst_b",          0, 0, 0, 1, 1, 3, 0, 0,  0, 0, 0);
    vec("rst_release",    1, 0, 0, 1, 1, 3, 0, 0,  3, 0, 0);
    vec("load22",         1, 1,22, 0, 1, 1, 0, 0, 22, 0, 0);
    vec("up_to_23",       1, 0, 0, 1, 1, 1, 0, 0, 23, 0, 0);
    vec("up_wrap_0",      1, 0, 0, 1, 1, 1, 0, 0,  0, 1, 1);
    vec("up_after_wrap",  1, 0, 0, 1, 1, 1, 0, 0,  1, 0, 1);
    vec("hold",           1, 0, 0, 0, 1, 1, 0, 0,  1, 0, 1);
    vec("clr_alone_a",    1, 0, 0, 0, 1, 1, 0, 1,  1, 0, 0);
    vec("load20_a",       1, 1,20, 0, 1, 5, 0, 0, 20, 0, 0);
    vec("up_wrap_step5",  1, 0, 0, 1, 1, 5, 0, 0,  1, 1, 1);
    vec("clr_b",          1, 0, 0, 0, 1, 5, 0, 1,  1, 0, 0);
    vec("load20_b",       1, 1,20, 0, 1, 5, 1, 0, 20, 0, 0);
    vec("up_sat_step5",   1, 0, 0, 1, 1, 5, 1, 0, 23, 1, 1);
    vec("clr_c",          1, 0, 0, 0, 1, 5, 1, 1, 23, 0, 0);
    vec("load1_a",        1, 1, 1, 0, 0, 3, 1, 0,  1, 0, 0);
    vec("dn_sat",         1, 0, 0, 1, 0, 3, 1, 0,  0, 1, 1);
    vec("load1_b",        1, 1, 1, 0, 0, 3, 0, 0,  1, 0, 1);
    vec("dn_wrap",        1, 0, 0, 1, 0, 3, 0, 0, 22, 1, 1);
    vec("clr_d",          1, 0, 0, 0, 0, 3, 0, 1, 22, 0, 0);
    vec("load_oor30_en",  1, 1,30, 1, 1, 1, 0, 0, 23, 0, 1);
    vec("load7",          1, 1, 7, 0, 1, 1, 0, 0,  7, 0, 1);
    vec("clr_e",          1, 0, 0, 0, 1, 1, 0, 1,  7, 0, 0);
    vec("load_oor24",     1, 1,24, 0, 1, 1, 0, 0, 23, 0, 1);
    vec("clr_f",          1, 0, 0, 0, 1, 1, 0, 1, 23, 0, 0);
    vec("load23_inrange", 1, 1,23, 0, 1, 1, 0, 0, 23, 0, 0);
    vec("up_step0",       1, 0, 0, 1, 1, 0, 0, 0, 23, 0, 0);
    vec("dn_step0",       1, 0, 0, 1, 0, 0, 0, 0, 23, 0, 0);
    vec("dn_step10",      1, 0, 0, 1, 0,10, 0, 0, 13, 0, 0);
    vec("dn_exact_zero",  1, 0, 0, 1, 0,13, 0, 0,  0, 0, 0);
    vec("dn_wrap_1",      1, 0, 0, 1, 0, 1, 0, 0, 23, 1, 1);
    vec("up_wrap_b2b",    1, 0, 0, 1, 1, 1, 0, 0,  0, 1, 1);
    vec("clr_vs_event",   1, 0, 0, 1, 0, 1, 0, 1, 23, 1, 1);
    vec("clr_g",          1, 0, 0, 0, 0, 1, 0, 1, 23, 0, 0);
    vec("up_sat_at_max",  1, 0, 0, 1, 1, 2, 1, 0, 23, 1, 1);
    vec("load_oor30",     1, 1,30, 0, 1, 1, 0, 0, 23, 0, 1);
    vec("load12",         1, 1,12, 0, 1, 1, 0, 0, 12, 0, 1);
    vec("rst_mid",        0, 1, 5, 1, 1, 1, 0, 0,  0, 0, 0);
    vec("rst_mid_rel",    1, 0, 0, 1, 1, 1, 0, 0,  1, 0, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
